// File: rtl/spell_rambus_sram_if.sv
// -----------------------------------------------------------------------------
// spell_rambus_sram_if
//   Wishbone classic bus between the spell core's RAMBus master port and the
//   byte-serialising SRAM slave.
//
//   i_wb_cyc   master -> slave  bus cycle
//   i_wb_stb   master -> slave  strobe
//   i_wb_we    master -> slave  1 = write, 0 = read
//   i_wb_sel   master -> slave  byte-lane select, bit k = bits [8k+7:8k]
//   i_wb_addr  master -> slave  byte address
//   i_wb_data  master -> slave  write data
//   o_wb_ack   slave -> master  single-cycle acknowledge
//   o_wb_data  slave -> master  read data, held until the next read completes
// -----------------------------------------------------------------------------
interface spell_rambus_sram_if;
   logic        i_wb_cyc;
   logic        i_wb_stb;
   logic        i_wb_we;
   logic [3:0]  i_wb_sel;
   logic [31:0] i_wb_addr;
   logic [31:0] i_wb_data;
   logic        o_wb_ack;
   logic [31:0] o_wb_data;

   modport master (
      output i_wb_cyc, i_wb_stb, i_wb_we, i_wb_sel, i_wb_addr, i_wb_data,
      input  o_wb_ack, o_wb_data
   );

   modport slave (
      input  i_wb_cyc, i_wb_stb, i_wb_we, i_wb_sel, i_wb_addr, i_wb_data,
      output o_wb_ack, o_wb_data
   );
endinterface

// File: rtl/spell_rambus_sram.sv
// -----------------------------------------------------------------------------
// spell_rambus_sram
//   Serves 32-bit Wishbone word accesses from an 8-bit-wide SRAM macro by
//   splitting each word into up to four sequential byte accesses.
//
//   wb_clk_i     in   clock, rising edge
//   wb_rst_i     in   synchronous active-high reset
//   wb           slave modport of spell_rambus_sram_if (Wishbone side)
//   o_ram_en     out  macro access enable (active-high)
//   o_ram_we     out  macro write enable, only meaningful with o_ram_en
//   o_ram_addr   out  macro byte address = {word index, lane}
//   o_ram_wdata  out  macro write byte
//   i_ram_rdata  in   macro read byte, valid the cycle after its enable
// -----------------------------------------------------------------------------
module spell_rambus_sram #(
   parameter int WORD_AW = 7
) (
   input  logic                 wb_clk_i,
   input  logic                 wb_rst_i,
   spell_rambus_sram_if.slave   wb,
   output logic                 o_ram_en,
   output logic                 o_ram_we,
   output logic [WORD_AW+1:0]   o_ram_addr,
   output logic [7:0]           o_ram_wdata,
   input  logic [7:0]           i_ram_rdata
);

   typedef enum logic [1:0] {IDLE, WRITE, READ, ACK} state_t;

   state_t             state;
   logic [WORD_AW-1:0] word_q;   // latched word index
   logic [31:0]        data_q;   // latched write data
   logic [3:0]         pend_q;   // write lanes still to be issued
   logic [2:0]         step_q;   // cycles spent in READ

   // Lowest set lane of a 4-bit mask (mask assumed non-zero by callers).
   function automatic logic [1:0] low_lane(input logic [3:0] m);
      if (m[0])      return 2'd0;
      else if (m[1]) return 2'd1;
      else if (m[2]) return 2'd2;
      else           return 2'd3;
   endfunction

   function automatic logic [7:0] lane_byte(input logic [31:0] d, input logic [1:0] l);
      return d[{l, 3'b000} +: 8];
   endfunction

   logic [WORD_AW-1:0] req_word;
   logic [1:0]         req_lane;   // first selected lane of an incoming write
   logic [1:0]         pend_lane;  // next pending lane of the current write
   logic [1:0]         cap_lane;   // lane whose read byte arrives this cycle

   assign req_word  = wb.i_wb_addr[WORD_AW+1:2];
   assign req_lane  = low_lane(wb.i_wb_sel);
   assign pend_lane = low_lane(pend_q);
   // Enable for lane k is issued at step k-1, so its data arrives at step k+1.
   assign cap_lane  = step_q[1:0] - 2'd1;

   // Address bits outside the word index alias onto the same memory.
   logic unused_addr;
   assign unused_addr = ^{wb.i_wb_addr[31:WORD_AW+2], wb.i_wb_addr[1:0]};

   always_ff @(posedge wb_clk_i) begin
      // NOTE: every register here is assigned with <= so all of them update
      // from the same pre-edge values; mixing in = would make the result
      // depend on statement order.
      if (wb_rst_i) begin
         state        <= IDLE;
         word_q       <= '0;
         data_q       <= '0;
         pend_q       <= '0;
         step_q       <= '0;
         wb.o_wb_ack  <= 1'b0;
         wb.o_wb_data <= '0;
         o_ram_en     <= 1'b0;
         o_ram_we     <= 1'b0;
         o_ram_addr   <= '0;
         o_ram_wdata  <= '0;
      end else begin
         wb.o_wb_ack <= 1'b0;

         case (state)
            IDLE: begin
               o_ram_en <= 1'b0;
               o_ram_we <= 1'b0;
               if (wb.i_wb_cyc && wb.i_wb_stb) begin
                  word_q <= req_word;
                  data_q <= wb.i_wb_data;
                  step_q <= '0;
                  if (wb.i_wb_we) begin
                     if (wb.i_wb_sel == 4'b0000) begin
                        pend_q      <= '0;
                        wb.o_wb_ack <= 1'b1;
                        state       <= ACK;
                     end else begin
                        // First lane is issued straight from the request so
                        // the enable lands in cycle 1.
                        o_ram_en    <= 1'b1;
                        o_ram_we    <= 1'b1;
                        o_ram_addr  <= {req_word, req_lane};
                        o_ram_wdata <= lane_byte(wb.i_wb_data, req_lane);
                        pend_q      <= wb.i_wb_sel & ~(4'b0001 << req_lane);
                        state       <= WRITE;
                     end
                  end else begin
                     o_ram_en   <= 1'b1;
                     o_ram_addr <= {req_word, 2'd0};
                     state      <= READ;
                  end
               end
            end

            WRITE: begin
               if (!wb.i_wb_cyc) begin
                  o_ram_en <= 1'b0;
                  o_ram_we <= 1'b0;
                  state    <= IDLE;
               end else if (pend_q != 4'b0000) begin
                  o_ram_en    <= 1'b1;
                  o_ram_we    <= 1'b1;
                  o_ram_addr  <= {word_q, pend_lane};
                  o_ram_wdata <= lane_byte(data_q, pend_lane);
                  pend_q      <= pend_q & ~(4'b0001 << pend_lane);
               end else begin
                  o_ram_en    <= 1'b0;
                  o_ram_we    <= 1'b0;
                  wb.o_wb_ack <= 1'b1;
                  state       <= ACK;
               end
            end

            READ: begin
               if (!wb.i_wb_cyc) begin
                  o_ram_en <= 1'b0;
                  state    <= IDLE;
               end else begin
                  step_q <= step_q + 3'd1;
                  // Steps 0..2 issue lanes 1..3; lane 0 was issued from IDLE.
                  if (step_q < 3'd3) begin
                     o_ram_en   <= 1'b1;
                     o_ram_addr <= {word_q, step_q[1:0] + 2'd1};
                  end else begin
                     o_ram_en <= 1'b0;
                  end
                  if (step_q != 3'd0) begin
                     wb.o_wb_data[{cap_lane, 3'b000} +: 8] <= i_ram_rdata;
                  end
                  if (step_q == 3'd4) begin
                     wb.o_wb_ack <= 1'b1;
                     state       <= ACK;
                  end
               end
            end

            ACK: begin
               // Strobe is deliberately not sampled here.
               o_ram_en <= 1'b0;
               o_ram_we <= 1'b0;
               state    <= IDLE;
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/spell_rambus_sram.md
# spell_rambus_sram

Byte-serialising Wishbone slave that serves the `spell` core's RAMBus master port (`rambus_wb_*`) from a single 8-bit-wide GF180 SRAM macro (512x8). Each 32-bit Wishbone word access becomes up to four sequential byte accesses on the macro port. The block sits directly downstream of `spell` inside `user_project_wrapper`; its `o_wb_ack` and `o_wb_data` outputs drive `rambus_wb_ack_i` and `rambus_wb_dat_i`.

## Interface

- `WORD_AW`, 7: word address width; macro byte address is `WORD_AW+2` bits (default 128 words = 512 bytes).
- `wb_clk_i`  in  1  clock; all logic on rising edge.
- `wb_rst_i`  in  1  reset; synchronous, active-high.
- `i_wb_cyc`  in  1  Wishbone cycle.
- `i_wb_stb`  in  1  Wishbone strobe.
- `i_wb_we`  in  1  1 = write, 0 = read.
- `i_wb_sel`  in  4  byte-lane select; bit k = bits [8k+7:8k].
- `i_wb_addr`  in  32  byte address; word index = `i_wb_addr[WORD_AW+1:2]`; other bits ignored (aliasing).
- `i_wb_data`  in  32  write data.
- `o_wb_ack`  out  1  single-cycle acknowledge.
- `o_wb_data`  out  32  read data; held until the next read completes.
- `o_ram_en`  out  1  macro access enable (active-high; wrapper inverts for CEN).
- `o_ram_we`  out  1  macro write enable, qualified by `o_ram_en`.
- `o_ram_addr`  out  `WORD_AW+2`  macro byte address = {word index, lane[1:0]}.
- `o_ram_wdata`  out  8  macro write byte.
- `i_ram_rdata`  in  8  macro read byte; valid in the cycle after the enabling cycle.

## Operation

- FSM states: IDLE, WRITE, READ, ACK.
- IDLE: samples request when `i_wb_cyc & i_wb_stb`. Latches word index, `we`, `sel`, and data; lane counter = 0.
- WRITE: walks lanes 0..3 in ascending order, skipping lanes with `sel` = 0. One macro cycle per selected lane: `o_ram_en`=1, `o_ram_we`=1, byte from the latched data. After the last selected lane, go to ACK. `sel`=4'b0000 goes straight to ACK with no macro cycles.
- READ: ignores `sel` and always reads lanes 0..3. Issue is pipelined: one enable per cycle. Byte k is captured into `o_wb_data[8k+7:8k]` one cycle after its enable. After the lane-3 capture, go to ACK.
- ACK: `o_wb_ack`=1 for exactly one cycle, then return to IDLE. The strobe is not sampled in ACK; the earliest next request is sampled in the cycle after ACK.
- Abort: if `i_wb_cyc` is low in WRITE or READ, go to IDLE at the next edge with no ack, and drop `o_ram_en` from then on. Bytes already written remain written. `o_wb_data` keeps the bytes already captured.
- Writes never modify `o_wb_data`.

## Timing

- Reset values: `o_wb_ack`=0, `o_wb_data`=0, `o_ram_en`=0, `o_ram_we`=0, `o_ram_addr`=0, `o_ram_wdata`=0; FSM = IDLE.
- Reset asserted mid-transaction abandons it next edge: no ack, macro enable low.
- All outputs are registered. Cycle 0 = the first cycle in which the request is visible in IDLE.
- Write with n selected lanes: enables in cycles 1..n; ack in cycle n+1. With n=0, ack in cycle 1.
- Read: enables in cycles 1..4 for lanes 0..3; captures at the ends of cycles 2..5; ack in cycle 6 with the full word valid on `o_wb_data`.
- `o_ram_en` is never high in IDLE or ACK.
- Back-to-back: a request held high through the ack is re-sampled in the cycle after ack as a new transaction. The master must drop `i_wb_stb` on ack.

## Test plan

- Full-word write then read: write 0xDEADBEEF, sel=F, addr 0x10 → macro writes EF,BE,AD,DE at byte addresses 0x10..0x13 in cycles 1-4; ack in cycle 5. A read of addr 0x10 gives ack in cycle 6 with `o_wb_data`=0xDEADBEEF.
- Partial write: preload 0x11223344 at addr 0x20, then write 0xAABBCCDD with sel=4'b1010 → macro cycles only at 0x21 (CC) and 0x23 (AA); ack in cycle 3. Read-back = 0xAA22CC44.
- Zero sel: write with sel=0 → no `o_ram_en` pulse; ack in cycle 1; memory unchanged.
- Alias/wrap: write 0x01020304 at addr 0x1FC, then read addr 0x3FC (WORD_AW=7) → returns 0x01020304; `o_ram_addr` spans 0x1FC..0x1FF.
- Abort: drop `i_wb_cyc` in cycle 2 of a sel=F write of 0xCAFEF00D → no ack; `o_ram_en` low from cycle 3. Only bytes issued through cycle 2 are written, so read-back shows 0D,F0 in lanes 0-1.
- Reset mid-read: assert `wb_rst_i` in cycle 3 of a read → next cycle all outputs zero and FSM IDLE. A subsequent read completes normally with a 6-cycle latency.
